// File: rtl/data_ram_responder.sv
// data_ram_responder: byte-addressed big-endian data memory for the MEM stage,
// answering MFA requests with a one-cycle MOC pulse after a programmable latency.
module data_ram_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  DataSize,
    input  logic [31:0] AddressIn,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err,
    output logic        Busy
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

    state_t state, nextState;
    logic [CW-1:0] cnt;
    logic [31:0] reqAddr, reqData, rdData;
    logic reqRw;
    logic [1:0] reqSize;
    logic [7:0] mem [DEPTH_BYTES];
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic accept, complete, reqErr;

    assign MOC = state == DONE;
    assign Busy = state == BUSY;

    always_comb begin
        accept = state == IDLE && MFA;
        complete = state == BUSY && cnt == '0;
        reqErr = reqSize == 2'b11 || reqAddr >= 32'(DEPTH_BYTES) ||
                 (reqSize == 2'b01 && reqAddr[0]) ||
                 (reqSize == 2'b10 && reqAddr[1:0] != 2'b00);
        // Alignment is checked first, so these offsets never cross the top of the array
        idx0 = reqAddr[AW-1:0];
        idx1 = idx0 + AW'(1);
        idx2 = idx0 + AW'(2);
        idx3 = idx0 + AW'(3);
        rdData = reqSize == 2'b00 ? {24'b0, mem[idx0]} :
                 reqSize == 2'b01 ? {16'b0, mem[idx0], mem[idx1]} :
                                    {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
        nextState = state;
        case (state)
            IDLE:    nextState = MFA ? BUSY : IDLE;
            BUSY:    nextState = complete ? DONE : BUSY;
            DONE:    nextState = MFA ? RELEASE : IDLE;
            RELEASE: nextState = MFA ? RELEASE : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt <= '0;
            reqAddr <= '0;
            reqData <= '0;
            reqRw <= 1'b0;
            reqSize <= 2'b00;
            Err <= 1'b0;
            DataOut <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                cnt <= CW'(LATENCY - 1);
                reqAddr <= AddressIn;
                reqData <= DataIn;
                reqRw <= RW;
                reqSize <= DataSize;
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
            end
            if (complete) begin
                Err <= reqErr;
                if (reqRw && !reqErr) DataOut <= rdData;
            end
        end
    end

    // The array has no reset; an aborted access never reaches the completing edge
    always_ff @(posedge Clk) begin
        if (complete && !reqRw && !reqErr) begin
            if (reqSize == 2'b00) begin
                mem[idx0] <= reqData[7:0];
            end else if (reqSize == 2'b01) begin
                mem[idx0] <= reqData[15:8];
                mem[idx1] <= reqData[7:0];
            end else begin
                mem[idx0] <= reqData[31:24];
                mem[idx1] <= reqData[23:16];
                mem[idx2] <= reqData[15:8];
                mem[idx3] <= reqData[7:0];
            end
        end
    end
endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Memory-side responder for the MEM-stage data interface: serves byte/halfword/word read and write requests from the pipeline's memory stage.
- Uses an MFA (memory function activate) / MOC (memory operation complete) handshake with a programmable access latency.
- Backing store is a byte-addressed, big-endian array.
- Sits between the MEM stage and storage; the stall unit holds the pipeline while MFA is high and MOC is low.

Parameters:
- DEPTH_BYTES, 256: number of bytes in the array. Must be a power of two.
- LATENCY, 2: clock edges from MFA acceptance to access and MOC. Minimum 1.

Ports:
- Clk  in  1: rising-edge clock.
- Reset_n  in  1: asynchronous, active-low reset.
- MFA  in  1: request strobe. Level signal, held high by the initiator until MOC is seen.
- RW  in  1: 1 = read, 0 = write.
- DataSize  in  2: 00 byte, 01 halfword, 10 word, 11 reserved.
- AddressIn  in  32: byte address.
- DataIn  in  32: write data, right-justified (byte in [7:0], halfword in [15:0]).
- DataOut  out  32: read data, zero-extended, right-justified.
- MOC  out  1: one-cycle completion pulse.
- Err  out  1: error flag, valid while MOC is high.
- Busy  out  1: high from request acceptance until MOC.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - MOC=0, Err=0, Busy=0, DataOut=0, latency counter=0.
  - Array contents are not cleared.
  - Reset mid-operation aborts the access; a pending write is not performed.
- States: IDLE, BUSY, DONE, RELEASE.
- IDLE:
  - On a rising edge with MFA=1, latch AddressIn, DataIn, RW and DataSize into request registers.
  - Load counter with LATENCY-1, set Busy=1, go to BUSY.
  - The initiator may change its inputs after acceptance; the latched copies are used.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter is 0: perform the access, set MOC=1, set Err, clear Busy, go to DONE.
  - With LATENCY=1, the edge after acceptance completes the access.
  - Net timing: MFA sampled at edge k, so MOC is high during the cycle after edge k+LATENCY.
- DONE:
  - MOC=1 for exactly one cycle.
  - Next edge clears MOC: go to IDLE if MFA=0, else go to RELEASE.
- RELEASE:
  - Waits for MFA=0, then goes to IDLE.
  - A held MFA never starts a second access; each access needs an MFA low-to-high sequence.
- Error conditions, checked on the latched request:
  - Halfword with addr[0]≠0.
  - Word with addr[1:0]≠0.
  - DataSize=11.
  - addr ≥ DEPTH_BYTES.
  - On error: no write occurs, DataOut is unchanged, Err=1 with MOC. Otherwise Err=0.
- Read, big-endian, with a = latched address:
  - Byte: DataOut = {24'b0, M[a]}.
  - Halfword: DataOut = {16'b0, M[a], M[a+1]}.
  - Word: DataOut = {M[a], M[a+1], M[a+2], M[a+3]}.
  - DataOut updates on the completing edge and holds until the next successful read completes. Writes and errors do not change it.
- Write:
  - Byte: M[a] = D[7:0].
  - Halfword: M[a] = D[15:8], M[a+1] = D[7:0].
  - Word: M[a..a+3] = D[31:24], D[23:16], D[15:8], D[7:0].
  - Written on the completing edge only.
- Address indexing uses only the bits needed for DEPTH_BYTES after the range check. There is no wrap-around; out-of-range addresses error.
- MFA dropping while in BUSY:
  - The access still completes and MOC still pulses.
  - The next state is then IDLE.
- The array may be preloaded via $readmemh in simulation; this is not a port.

Test Plan:
- Word write/read: write 0xDEADBEEF to 0x10, then read word 0x10 with LATENCY=2.
  - Required: MOC rises 2 edges after MFA is sampled.
  - Required: DataOut=0xDEADBEEF, Err=0.
- Sub-word packing: write word 0x11223344 at 0x20.
  - Read byte 0x22 → 0x00000033.
  - Read halfword 0x22 → 0x00003344.
  - Write byte 0xAA to 0x21, then read word 0x20 → 0x11AA3344.
- Errors, each giving MOC with Err=1 and memory/DataOut unchanged:
  - Word read at 0x13.
  - Halfword write at 0x05.
  - DataSize=11.
  - Any access at address 0x100 (DEPTH_BYTES=256).
- Held MFA: keep MFA high for 10 cycles after one request.
  - Required: exactly one MOC pulse; the block stays in RELEASE.
  - After MFA goes low then high, a second access proceeds.
- Reset mid-access: assert Reset_n=0 during BUSY on a word write of 0xCAFEF00D to 0x40.
  - Required: MOC, Busy and DataOut are 0 immediately, with no clock edge needed.
  - Required: a later read of 0x40 returns the prior contents.
- LATENCY=1 back-to-back: issue alternating write/read requests with MFA low for one cycle between them.
  - Required: each MOC arrives 1 edge after acceptance.
  - Required: read data matches the preceding write.
